// File: rtl/load_scoreboard.sv
// ---------------------------------------------------------------------------
// load_scoreboard
//   Tracks which architectural registers are waiting for load data and how
//   many loads are in flight. Decode is held (stall) on a read-after-write or
//   write-after-write hazard against a pending load, or when a new load would
//   exceed MAX_OUTSTANDING. Data returning this cycle (ld_done) is forwarded,
//   so its register is treated as already available.
//
// Parameters
//   MAX_OUTSTANDING  maximum number of in-flight loads (1..3)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   ld_issue        a load leaves decode this cycle
//   ld_issue_rd     destination register of the issuing load
//   ld_done         load data returns this cycle
//   ld_done_rd      destination register of the returning load
//   dec_rs1_src     rs1 index of the decode instruction
//   dec_rs2_src     rs2 index of the decode instruction
//   dec_use_rs1     decode instruction reads rs1
//   dec_use_rs2     decode instruction reads rs2
//   dec_is_load     decode instruction is a load
//   dec_rd_src      rd index of the decode instruction
//   stall           hold decode this cycle (combinational)
//   ld_pending_cnt  number of in-flight loads
// ---------------------------------------------------------------------------
module load_scoreboard #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_issue,
  input  logic [4:0] ld_issue_rd,
  input  logic       ld_done,
  input  logic [4:0] ld_done_rd,
  input  logic [4:0] dec_rs1_src,
  input  logic [4:0] dec_rs2_src,
  input  logic       dec_use_rs1,
  input  logic       dec_use_rs2,
  input  logic       dec_is_load,
  input  logic [4:0] dec_rd_src,
  output logic       stall,
  output logic [1:0] ld_pending_cnt
);

  localparam logic [1:0] MAX_CNT = MAX_OUTSTANDING[1:0];

  // Bit 0 (x0) is never stored; it is tied to zero in w_pend.
  logic [31:1] r_pend;
  logic [1:0]  r_cnt;

  logic [31:0] w_pend;
  logic [31:0] w_done_mask;
  logic [31:1] w_set_mask;
  logic [31:0] w_busy;
  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_full;
  logic        w_issue;
  logic        w_inc;
  logic        w_dec;

  assign w_pend = {r_pend, 1'b0};

  // One-hot masks for the returning and the issuing register.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_done_mask = '0;
    w_set_mask  = '0;
    for (int i = 0; i < 32; i++) begin
      w_done_mask[i] = ld_done && (ld_done_rd == 5'(i));
    end
    for (int i = 1; i < 32; i++) begin
      w_set_mask[i] = w_issue && (ld_issue_rd == 5'(i));
    end
  end

  // A register whose data is returning this cycle is forwarded, so it is not
  // a hazard for decode.
  assign w_busy = w_pend & ~w_done_mask;

  assign w_raw1 = dec_use_rs1 && (dec_rs1_src != 5'd0) && w_busy[dec_rs1_src];
  assign w_raw2 = dec_use_rs2 && (dec_rs2_src != 5'd0) && w_busy[dec_rs2_src];
  assign w_waw  = dec_is_load && (dec_rd_src != 5'd0) && w_busy[dec_rd_src];
  // A returning load frees a slot in the same cycle.
  assign w_full = dec_is_load && (r_cnt == MAX_CNT) && !ld_done;

  assign stall = w_raw1 || w_raw2 || w_waw || w_full;

  // An issue presented while stalled is an upstream error and is dropped.
  assign w_issue = ld_issue && !stall;

  // Saturating count: overflow at MAX and underflow at 0 leave it unchanged.
  assign w_inc = w_issue && !ld_done && (r_cnt != MAX_CNT);
  assign w_dec = ld_done && !w_issue && (r_cnt != 2'd0);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_cnt  <= 2'd0;
    end else begin
      // Clear first, then set, so a same-edge issue to the returning
      // register keeps it pending.
      r_pend <= (r_pend & ~w_done_mask[31:1]) | w_set_mask;
      if (w_inc) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign ld_pending_cnt = r_cnt;

endmodule

// File: tb/tb_load_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_load_scoreboard
//   Directed bench for load_scoreboard (MAX_OUTSTANDING = 2). A behavioural
//   model holds the set of pending registers and the in-flight count; a
//   compare process checks stall and ld_pending_cnt against it every falling
//   edge. Directed scenarios add literal expectations at each step.
// ---------------------------------------------------------------------------
module tb_load_scoreboard;

  localparam int MAXO = 2;

  logic       clk;
  logic       rst;
  logic       ld_issue;
  logic [4:0] ld_issue_rd;
  logic       ld_done;
  logic [4:0] ld_done_rd;
  logic [4:0] dec_rs1_src;
  logic [4:0] dec_rs2_src;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic       dec_is_load;
  logic [4:0] dec_rd_src;
  logic       stall;
  logic [1:0] ld_pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  load_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_done        (ld_done),
    .ld_done_rd     (ld_done_rd),
    .dec_rs1_src    (dec_rs1_src),
    .dec_rs2_src    (dec_rs2_src),
    .dec_use_rs1    (dec_use_rs1),
    .dec_use_rs2    (dec_use_rs2),
    .dec_is_load    (dec_is_load),
    .dec_rd_src     (dec_rd_src),
    .stall          (stall),
    .ld_pending_cnt (ld_pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend [32];
  int m_cnt;

  // A register is a hazard when some load still owes it data and that data
  // is not arriving this very cycle.
  function automatic bit m_waiting(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (ld_done && ld_done_rd == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    if (dec_use_rs1 && m_waiting(dec_rs1_src)) s = 1'b1;
    if (dec_use_rs2 && m_waiting(dec_rs2_src)) s = 1'b1;
    if (dec_is_load && m_waiting(dec_rd_src)) s = 1'b1;
    if (dec_is_load && m_cnt == MAXO && !ld_done) s = 1'b1;
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit iss;
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
      m_cnt <= 0;
    end else begin
      iss = ld_issue && !m_stall();
      if (ld_done) m_pend[ld_done_rd] <= 1'b0;
      if (iss && ld_issue_rd != 5'd0) m_pend[ld_issue_rd] <= 1'b1;
      if (iss && !ld_done && m_cnt < MAXO) m_cnt <= m_cnt + 1;
      else if (ld_done && !iss && m_cnt > 0) m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    check("cmp_stall", int'(stall), int'(m_stall()));
    check("cmp_cnt", int'(ld_pending_cnt), m_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    ld_issue    = 1'b0; ld_issue_rd = 5'd0;
    ld_done     = 1'b0; ld_done_rd  = 5'd0;
    dec_rs1_src = 5'd0; dec_rs2_src = 5'd0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    dec_is_load = 1'b0; dec_rd_src  = 5'd0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    clr();
    ld_issue = 1'b1; ld_issue_rd = rd;
    tick();
  endtask

  task automatic done(input logic [4:0] rd);
    clr();
    ld_done = 1'b1; ld_done_rd = rd;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clr();
    #3;
    check("rst_stall", int'(stall), 0);
    check("rst_cnt", int'(ld_pending_cnt), 0);
    #14 rst = 1'b1;
    tick();

    // load-use on x5
    issue(5'd5);
    clr(); dec_use_rs1 = 1'b1; dec_rs1_src = 5'd5; settle();
    check("lu_stall", int'(stall), 1);
    check("lu_cnt1", int'(ld_pending_cnt), 1);
    tick();
    ld_done = 1'b1; ld_done_rd = 5'd5; settle();
    check("lu_bypass", int'(stall), 0);
    tick();
    clr(); dec_use_rs1 = 1'b1; dec_rs1_src = 5'd5; settle();
    check("lu_cleared", int'(stall), 0);
    check("lu_cnt0", int'(ld_pending_cnt), 0);

    // rs2 hazard and its use qualifier
    issue(5'd5);
    clr(); dec_rs1_src = 5'd5; dec_rs2_src = 5'd5; settle();
    check("rs_dontcare", int'(stall), 0);
    dec_use_rs2 = 1'b1; settle();
    check("rs2_stall", int'(stall), 1);
    done(5'd5);

    // x0 load
    issue(5'd0);
    clr(); dec_use_rs1 = 1'b1; dec_rs1_src = 5'd0; settle();
    check("x0_stall", int'(stall), 0);
    check("x0_cnt1", int'(ld_pending_cnt), 1);
    done(5'd0);
    check("x0_cnt0", int'(ld_pending_cnt), 0);

    // done at zero count does not wrap
    done(5'd3);
    check("under_cnt", int'(ld_pending_cnt), 0);

    // full
    issue(5'd1);
    issue(5'd2);
    clr(); dec_is_load = 1'b1; dec_rd_src = 5'd3; settle();
    check("full_stall", int'(stall), 1);
    check("full_cnt", int'(ld_pending_cnt), 2);
    ld_done = 1'b1; ld_done_rd = 5'd1; settle();
    check("full_bypass", int'(stall), 0);
    tick();
    clr(); settle();
    check("full_cnt1", int'(ld_pending_cnt), 1);
    done(5'd2);
    check("full_cnt0", int'(ld_pending_cnt), 0);

    // simultaneous issue and done to x7
    issue(5'd7);
    clr(); ld_issue = 1'b1; ld_issue_rd = 5'd7; ld_done = 1'b1; ld_done_rd = 5'd7;
    tick();
    clr(); dec_use_rs1 = 1'b1; dec_rs1_src = 5'd7; settle();
    check("sim_pend", int'(stall), 1);
    check("sim_cnt", int'(ld_pending_cnt), 1);
    done(5'd7);

    // WAW on x9; an issue while stalled is dropped
    issue(5'd9);
    clr(); dec_is_load = 1'b1; dec_rd_src = 5'd9;
    ld_issue = 1'b1; ld_issue_rd = 5'd9; settle();
    check("waw_stall", int'(stall), 1);
    tick();
    clr(); settle();
    check("waw_cnt", int'(ld_pending_cnt), 1);
    dec_is_load = 1'b1; dec_rd_src = 5'd9; ld_done = 1'b1; ld_done_rd = 5'd9; settle();
    check("waw_bypass", int'(stall), 0);
    tick();
    clr(); settle();
    check("waw_cnt0", int'(ld_pending_cnt), 0);

    // overflow attempt, then mid-operation reset
    issue(5'd4);
    issue(5'd6);
    issue(5'd10);
    clr(); settle();
    check("over_cnt", int'(ld_pending_cnt), 2);
    dec_use_rs2 = 1'b1; dec_rs2_src = 5'd4; settle();
    check("pre_rst_stall", int'(stall), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_cnt", int'(ld_pending_cnt), 0);
    check("mid_rst_stall", int'(stall), 0);
    #1 rst = 1'b1;
    tick();
    check("post_rst_stall", int'(stall), 0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
